// File: rtl/quantum_context_timer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | quantum_context_timer_if                                                   |
// | CPU/scheduler-side bundle of the time-slice and context-switch controller. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface quantum_context_timer_if #(
    parameter int PROC_W = 3
);
    logic [31:0]       pc;
    logic              parada;
    logic              instrucao_io;
    logic              fim_processo;
    logic              despacho;
    logic [PROC_W-1:0] processo_novo;
    logic [PROC_W-1:0] tabela_idx;
    logic [1:0]        troca_contexto;
    logic              intrucao_io_contexto;
    logic [31:0]       pc_processo_trocado;
    logic [PROC_W-1:0] processo_atual;
    logic [31:0]       tabela_pc;
    logic [15:0]       contagem;

    modport master (
        output pc, parada, instrucao_io, fim_processo, despacho, processo_novo, tabela_idx,
        input  troca_contexto, intrucao_io_contexto, pc_processo_trocado, processo_atual,
               tabela_pc, contagem
    );

    modport slave (
        input  pc, parada, instrucao_io, fim_processo, despacho, processo_novo, tabela_idx,
        output troca_contexto, intrucao_io_contexto, pc_processo_trocado, processo_atual,
               tabela_pc, contagem
    );
endinterface
`default_nettype wire

// File: rtl/quantum_context_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | quantum_context_timer                                                      |
// | Quantum counter and context-switch request generator with resume-PC save.  |
// | QUANTUM_PC_TABLE_EN builds the per-process resume-PC table.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module quantum_context_timer #(
    parameter int QUANTUM = 16,
    parameter int NPROC   = 8,
    parameter int PROC_W  = 3
) (
    input  wire logic               clk,
    input  wire logic               reset,
    quantum_context_timer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SWITCH = 2'd2,
        WAIT   = 2'd3
    } state_t;

    localparam logic [15:0] c_lastCount = 16'(QUANTUM - 1);

    state_t            r_state, w_stateNext;
    logic [1:0]        r_troca, w_trocaNext;
    logic              r_ioCtx;
    logic [31:0]       r_pcTrocado, w_pcTrocadoNext;
    logic [PROC_W-1:0] r_procAtual, w_procAtualNext;
    logic [15:0]       r_contagem, w_contagemNext;
    logic [31:0]       r_tabelaPc;
    logic              w_tableWr;
    logic [31:0]       w_resumePc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_troca     <= 2'b00;
            r_ioCtx     <= 1'b0;
            r_pcTrocado <= 32'd0;
            r_procAtual <= '0;
            r_contagem  <= 16'd0;
        end else begin
            r_state     <= w_stateNext;
            r_troca     <= w_trocaNext;
            r_ioCtx     <= (w_trocaNext == 2'b01);
            r_pcTrocado <= w_pcTrocadoNext;
            r_procAtual <= w_procAtualNext;
            r_contagem  <= w_contagemNext;
        end
    end

    always_comb begin
        w_stateNext     = r_state;
        w_trocaNext     = 2'b00;
        w_pcTrocadoNext = r_pcTrocado;
        w_procAtualNext = r_procAtual;
        w_contagemNext  = r_contagem;
        w_tableWr       = 1'b0;
        w_resumePc      = 32'd0;
        case (r_state)
            IDLE, WAIT: begin
                if (bus.despacho) begin
                    if (bus.processo_novo != '0) begin
                        w_stateNext     = RUN;
                        w_procAtualNext = bus.processo_novo;
                        w_contagemNext  = 16'd0;
                    end else begin
                        w_stateNext = IDLE;
                    end
                end
            end
            RUN: begin
                // Termination beats I/O, which beats quantum expiry.
                if (bus.fim_processo) begin
                    w_trocaNext = 2'b10;
                    w_resumePc  = 32'd0;
                    w_tableWr   = 1'b1;
                end else if (bus.instrucao_io) begin
                    w_trocaNext = 2'b01;
                    w_resumePc  = bus.pc + 32'd1;
                    w_tableWr   = 1'b1;
                end else if (!bus.parada && r_contagem == c_lastCount) begin
                    w_trocaNext = 2'b11;
                    w_resumePc  = bus.pc;
                    w_tableWr   = 1'b1;
                end else if (!bus.parada) begin
                    w_contagemNext = r_contagem + 16'd1;
                end
                if (w_tableWr) begin
                    w_pcTrocadoNext = w_resumePc;
                    w_stateNext     = SWITCH;
                end
            end
            SWITCH: begin
                w_stateNext     = WAIT;
                w_contagemNext  = 16'd0;
                w_procAtualNext = '0;
            end
            default: w_stateNext = IDLE;
        endcase
    end

`ifdef QUANTUM_PC_TABLE_EN
    logic [31:0] r_table [NPROC];

    // Registered read before the write lands: same-slot collisions return the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NPROC; i++) begin
                r_table[i] <= 32'd0;
            end
            r_tabelaPc <= 32'd0;
        end else begin
            r_tabelaPc <= r_table[bus.tabela_idx];
            if (w_tableWr) begin
                r_table[r_procAtual] <= w_resumePc;
            end
        end
    end
`else
    localparam int c_unusedNproc = NPROC;
    logic w_unusedTable;
    assign w_unusedTable = ^{bus.tabela_idx, w_tableWr};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tabelaPc <= 32'd0;
        end else begin
            r_tabelaPc <= r_pcTrocado;
        end
    end
`endif

    assign bus.troca_contexto       = r_troca;
    assign bus.intrucao_io_contexto = r_ioCtx;
    assign bus.pc_processo_trocado  = r_pcTrocado;
    assign bus.processo_atual       = r_procAtual;
    assign bus.tabela_pc            = r_tabelaPc;
    assign bus.contagem             = r_contagem;
endmodule
`default_nettype wire

// File: tb/tb_quantum_context_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_quantum_context_timer                                                   |
// | Directed and randomized checks against a cycle-level reference model.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_quantum_context_timer;
    localparam int QUANTUM = 16;
    localparam int NPROC   = 8;
    localparam int PROC_W  = 3;

    localparam int MODE_SCHED  = 0;
    localparam int MODE_USER   = 1;
    localparam int MODE_REQ    = 2;
    localparam int MODE_PARKED = 3;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    quantum_context_timer_if #(.PROC_W(PROC_W)) bus ();

    quantum_context_timer #(
        .QUANTUM(QUANTUM),
        .NPROC  (NPROC),
        .PROC_W (PROC_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          mMode;
    int          mPid;
    int          mCount;
    logic [1:0]  mReq;
    logic [31:0] mSaved;
    logic [31:0] mTab;
    logic [31:0] mSlots [NPROC];

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mMode  = MODE_SCHED;
        mPid   = 0;
        mCount = 0;
        mReq   = 2'b00;
        mSaved = 32'd0;
        mTab   = 32'd0;
        for (int i = 0; i < NPROC; i++) mSlots[i] = 32'd0;
    endtask

    task automatic modelStep();
        int          code;
        logic [31:0] resume;
        if (reset) begin
            modelReset();
            return;
        end
`ifdef QUANTUM_PC_TABLE_EN
        mTab = mSlots[int'(bus.tabela_idx)];
`else
        mTab = mSaved;
`endif
        code   = 0;
        resume = 32'd0;
        mReq   = 2'b00;
        if (mMode == MODE_SCHED || mMode == MODE_PARKED) begin
            if (bus.despacho) begin
                if (bus.processo_novo != 0) begin
                    mMode  = MODE_USER;
                    mPid   = int'(bus.processo_novo);
                    mCount = 0;
                end else begin
                    mMode = MODE_SCHED;
                end
            end
        end else if (mMode == MODE_USER) begin
            if (bus.fim_processo) code = 2;
            else if (bus.instrucao_io) begin
                code   = 1;
                resume = bus.pc + 32'd1;
            end else if (!bus.parada && mCount == QUANTUM - 1) begin
                code   = 3;
                resume = bus.pc;
            end else if (!bus.parada) mCount++;
            if (code != 0) begin
                mReq         = 2'(code);
                mSaved       = resume;
                mSlots[mPid] = resume;
                mMode        = MODE_REQ;
            end
        end else begin
            mMode  = MODE_PARKED;
            mCount = 0;
            mPid   = 0;
        end
    endtask

    task automatic compareAll();
        checkValue("troca", 32'(bus.troca_contexto), 32'(mReq));
        checkValue("ioCtx", 32'(bus.intrucao_io_contexto), 32'(mReq == 2'b01));
        checkValue("pcTrocado", bus.pc_processo_trocado, mSaved);
        checkValue("procAtual", 32'(bus.processo_atual), 32'(mPid));
        checkValue("contagem", 32'(bus.contagem), 32'(mCount));
        checkValue("tabelaPc", bus.tabela_pc, mTab);
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        compareAll();
    endtask

    task automatic dispatch(input int id);
        bus.despacho      = 1'b1;
        bus.processo_novo = PROC_W'(id);
        tick();
        bus.despacho = 1'b0;
    endtask

    task automatic runUntilReq(input int maxCycles, output int n);
        n = 0;
        while (bus.troca_contexto == 2'b00 && n < maxCycles) begin
            tick();
            n++;
        end
        if (bus.troca_contexto == 2'b00) checkValue("reqTimeout", 32'(n), 32'(maxCycles + 1));
    endtask

    initial begin
        int n;
        int spurious;
        checks   = 0;
        failures = 0;
        modelReset();
        reset             = 1'b1;
        bus.pc            = 32'd0;
        bus.parada        = 1'b0;
        bus.instrucao_io  = 1'b0;
        bus.fim_processo  = 1'b0;
        bus.despacho      = 1'b0;
        bus.processo_novo = '0;
        bus.tabela_idx    = '0;
        tick();
        tick();
        reset = 1'b0;
        checkValue("rstTroca", 32'(bus.troca_contexto), 32'd0);
        checkValue("rstPcTrocado", bus.pc_processo_trocado, 32'd0);
        checkValue("rstProc", 32'(bus.processo_atual), 32'd0);
        checkValue("rstContagem", 32'(bus.contagem), 32'd0);
        checkValue("rstTabela", bus.tabela_pc, 32'd0);

        // Full quantum at a fixed PC
        bus.pc = 32'h40;
        dispatch(3);
        checkValue("dispProc", 32'(bus.processo_atual), 32'd3);
        runUntilReq(40, n);
        checkValue("quantumLen", 32'(n), 32'(QUANTUM));
        checkValue("expiryCode", 32'(bus.troca_contexto), 32'd3);
        checkValue("expiryPc", bus.pc_processo_trocado, 32'h40);
        bus.tabela_idx = 3'd3;
        tick();
        checkValue("slot3", bus.tabela_pc, 32'h40);
        checkValue("expiryOneCycle", 32'(bus.troca_contexto), 32'd0);

        // Halt mid-quantum stretches it by the halt length
        bus.pc = 32'h100;
        dispatch(2);
        repeat (4) tick();
        checkValue("preHalt", 32'(bus.contagem), 32'd4);
        bus.parada = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkValue("haltHold", 32'(bus.contagem), 32'd4);
        end
        bus.parada = 1'b0;
        runUntilReq(40, n);
        checkValue("haltQuantum", 32'(n + 9), 32'(QUANTUM + 5));
        tick();

        // Termination wins over I/O and clears the slot
        bus.pc = 32'h7F;
        dispatch(4);
        runUntilReq(40, n);
        tick();
        dispatch(4);
        tick();
        bus.instrucao_io = 1'b1;
        bus.fim_processo = 1'b1;
        tick();
        checkValue("fimCode", 32'(bus.troca_contexto), 32'd2);
        checkValue("fimIoCtx", 32'(bus.intrucao_io_contexto), 32'd0);
        checkValue("fimPc", bus.pc_processo_trocado, 32'd0);
        bus.instrucao_io = 1'b0;
        bus.fim_processo = 1'b0;
        bus.tabela_idx   = 3'd4;
        tick();
        checkValue("slot4Cleared", bus.tabela_pc, 32'd0);

        // I/O resume PC wraps
        bus.pc = 32'hFFFF_FFFF;
        dispatch(1);
        bus.instrucao_io = 1'b1;
        tick();
        bus.instrucao_io = 1'b0;
        checkValue("ioCode", 32'(bus.troca_contexto), 32'd1);
        checkValue("ioCtx", 32'(bus.intrucao_io_contexto), 32'd1);
        checkValue("ioWrap", bus.pc_processo_trocado, 32'd0);
        tick();

        // Reset during SWITCH aborts the request
        bus.pc = 32'h200;
        dispatch(5);
        bus.instrucao_io = 1'b1;
        tick();
        bus.instrucao_io = 1'b0;
        checkValue("preRstReq", 32'(bus.troca_contexto), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkValue("rstSwitchTroca", 32'(bus.troca_contexto), 32'd0);
        bus.tabela_idx = 3'd3;
        tick();
        checkValue("rstSlot3", bus.tabela_pc, 32'd0);

        // Dispatch during SWITCH is ignored
        bus.pc = 32'h300;
        dispatch(6);
        bus.fim_processo = 1'b1;
        tick();
        bus.fim_processo = 1'b0;
        dispatch(7);
        checkValue("switchDispProc", 32'(bus.processo_atual), 32'd0);
        tick();
        checkValue("switchDispCount", 32'(bus.contagem), 32'd0);

        // Dispatch of the scheduler id never starts a quantum
        dispatch(0);
        spurious = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.troca_contexto != 2'b00) spurious++;
        end
        checkValue("idleNoReq", 32'(spurious), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bus.pc            = $urandom;
            bus.parada        = ($urandom_range(0, 3) == 0);
            bus.instrucao_io  = ($urandom_range(0, 15) == 0);
            bus.fim_processo  = ($urandom_range(0, 31) == 0);
            bus.despacho      = ($urandom_range(0, 7) == 0);
            bus.processo_novo = PROC_W'($urandom_range(0, NPROC - 1));
            bus.tabela_idx    = PROC_W'($urandom_range(0, NPROC - 1));
            reset             = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/quantum_context_timer.md
# quantum_context_timer

Time-slice and context-switch controller that sits directly upstream of the CPU's PC-update logic. It counts the quantum of the running user process and detects I/O instructions and process termination. It raises a one-cycle `troca_contexto` / `intrucao_io_contexto` request that redirects the PC to the scheduler or the I/O handler. It also saves the interrupted process's resume PC for the scheduler to read through the `pc_contexto` register-write path.

## Interface
Parameters:
- `QUANTUM`, default 16: clock cycles a user process runs before preemption (≥2).
- `NPROC`, default 8: number of process slots; process 0 is the scheduler/OS and is never time-sliced.
- `PROC_W`, default 3: width of process index (log2 NPROC).

Ports:
- `clk`, input, 1: system clock (divided clock); the only clock.
- `reset`, input, 1: synchronous, active-high.
- `pc`, input, 32: current CPU PC.
- `parada`, input, 1: CPU halted; freezes quantum count.
- `instrucao_io`, input, 1: current instruction is an I/O instruction (level, sampled per cycle).
- `fim_processo`, input, 1: current instruction terminates the process.
- `despacho`, input, 1: one-cycle pulse; scheduler dispatches `processo_novo`.
- `processo_novo`, input, PROC_W: process id being dispatched.
- `tabela_idx`, input, PROC_W: PC-table read index.
- `troca_contexto`, output, 2: 00 none, 01 I/O, 10 end of process, 11 quantum expired.
- `intrucao_io_contexto`, output, 1: high exactly when `troca_contexto==01`.
- `pc_processo_trocado`, output, 32: resume PC of the last switched-out process.
- `processo_atual`, output, PROC_W: running process id.
- `tabela_pc`, output, 32: saved PC of slot `tabela_idx`.
- `contagem`, output, 16: cycles consumed in the current quantum.

## Operation
- States: IDLE (scheduler/BIOS running, no counting), RUN, SWITCH, WAIT.
- IDLE: on `despacho` with `processo_novo≠0`, latch the id into `processo_atual`, clear `contagem`, go to RUN. `despacho` with id 0 stays in IDLE.
- RUN, evaluated each cycle with priority `fim_processo` > `instrucao_io` > expiry:
  - `fim_processo`: code 10; table slot cleared to 0; `pc_processo_trocado`=0.
  - `instrucao_io`: code 01; resume PC = `pc+1` (32-bit wrap).
  - Expiry: `contagem==QUANTUM-1` and `!parada` gives code 11; resume PC = `pc`.
  - On any event, write the resume PC to `pc_processo_trocado` and table slot `processo_atual`, then go to SWITCH.
  - Otherwise `contagem` increments when `!parada` and holds while `parada` is high.
- SWITCH: request is visible for exactly this one cycle. Next state is WAIT; `contagem` clears.
- WAIT: all requests are 00. `despacho` behaves as in IDLE. `processo_atual` is set to 0 in WAIT.
- `despacho` is ignored in RUN and SWITCH.
- `parada` does not suppress `fim_processo` or `instrucao_io` detection.
- A table write and a read of the same slot in the same cycle return the old value; the new value appears the cycle after.

## Timing
- All outputs are registered and updated on the `posedge clk`.
- Event sampled at edge N: `troca_contexto` and `pc_processo_trocado` are valid from edge N+1 for one cycle. The CPU loads the scheduler or I/O PC at edge N+2.
- `despacho` at edge N: RUN and `processo_atual` are valid after edge N+1. The first counted cycle is N+1.
- With `parada` low, a full quantum is QUANTUM cycles from dispatch to request assertion.
- `tabela_pc` read latency is 1 cycle.
- Reset values: state IDLE; `troca_contexto`=00; `intrucao_io_contexto`=0; `pc_processo_trocado`=0; `processo_atual`=0; `contagem`=0; `tabela_pc`=0; all table slots 0.
- `reset` mid-RUN or mid-SWITCH aborts any pending request on that edge.

## Configuration
- `QUANTUM_PC_TABLE_EN` defined: the NPROC×32 table is built; `tabela_pc` returns saved slots.
- `QUANTUM_PC_TABLE_EN` undefined: no table is built. `tabela_pc` is tied to `pc_processo_trocado`, delayed by one cycle, and `tabela_idx` is ignored. The scheduler must consume the resume PC before the next dispatch.

## Test plan
- Reset, then `despacho` with id 3 and `pc` held at 0x40, QUANTUM=16, `parada`=0 -> `troca_contexto`=11 for one cycle, 16 cycles after RUN entry; `pc_processo_trocado`=0x40; table[3]=0x40.
- In RUN for process 2, `parada` high for 5 cycles mid-quantum -> expiry is delayed by exactly 5 cycles; `contagem` holds its value while `parada` is high.
- `instrucao_io` and `fim_processo` asserted together at `pc`=0x7F -> code 10 (not 01); `intrucao_io_contexto`=0; table slot cleared to 0.
- `instrucao_io` at `pc`=0xFFFFFFFF -> code 01, `intrucao_io_contexto`=1, resume PC 0x00000000.
- `reset` asserted during SWITCH -> the next cycle shows `troca_contexto`=00, state IDLE, all table slots 0; a `despacho` during SWITCH (no reset) is ignored.
- `despacho` with id 0 from WAIT -> stays IDLE; no request is raised after 100 cycles.
